// File: rtl/des_perm_pipe.sv
// Pipelined DES IP/FP bit-permutation engine with valid/ready handshake and global stall.
// Optional output self-check enabled by defining DES_PERM_SELFCHECK_EN.
module des_perm_pipe #(
    parameter int unsigned PIPE_STAGES = 2,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [63:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_mode,
    output logic [63:0]      out_data,
    output logic [CNT_W-1:0] blk_cnt,
    output logic             chk_err
);

    // Entry i names the 1-indexed DES source bit for 1-indexed output bit i+1.
    localparam logic [6:0] IP_TAB [64] = '{
        7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18, 7'd10, 7'd2,
        7'd60, 7'd52, 7'd44, 7'd36, 7'd28, 7'd20, 7'd12, 7'd4,
        7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22, 7'd14, 7'd6,
        7'd64, 7'd56, 7'd48, 7'd40, 7'd32, 7'd24, 7'd16, 7'd8,
        7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,  7'd1,
        7'd59, 7'd51, 7'd43, 7'd35, 7'd27, 7'd19, 7'd11, 7'd3,
        7'd61, 7'd53, 7'd45, 7'd37, 7'd29, 7'd21, 7'd13, 7'd5,
        7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15, 7'd7
    };

    localparam logic [6:0] FP_TAB [64] = '{
        7'd40, 7'd8, 7'd48, 7'd16, 7'd56, 7'd24, 7'd64, 7'd32,
        7'd39, 7'd7, 7'd47, 7'd15, 7'd55, 7'd23, 7'd63, 7'd31,
        7'd38, 7'd6, 7'd46, 7'd14, 7'd54, 7'd22, 7'd62, 7'd30,
        7'd37, 7'd5, 7'd45, 7'd13, 7'd53, 7'd21, 7'd61, 7'd29,
        7'd36, 7'd4, 7'd44, 7'd12, 7'd52, 7'd20, 7'd60, 7'd28,
        7'd35, 7'd3, 7'd43, 7'd11, 7'd51, 7'd19, 7'd59, 7'd27,
        7'd34, 7'd2, 7'd42, 7'd10, 7'd50, 7'd18, 7'd58, 7'd26,
        7'd33, 7'd1, 7'd41, 7'd9,  7'd49, 7'd17, 7'd57, 7'd25
    };

    // fp = 0 applies IP, fp = 1 applies FP; DES bit n lives at vector bit 64-n.
    function automatic logic [63:0] permute(input logic [63:0] d, input logic fp);
        logic [63:0] r;
        logic [6:0]  src;
        r = '0;
        for (int i = 0; i < 64; i++) begin
            src = fp ? FP_TAB[i] : IP_TAB[i];
            r[6'(63 - i)] = d[6'(7'd64 - src)];
        end
        return r;
    endfunction

    logic [PIPE_STAGES-1:0]       vld_q;
    logic [PIPE_STAGES-1:0]       mode_q;
    logic [PIPE_STAGES-1:0][63:0] data_q;
    logic [CNT_W-1:0]             cnt_q;
    logic                         stall;

    assign out_valid = vld_q[PIPE_STAGES-1];
    assign out_mode  = mode_q[PIPE_STAGES-1];
    assign out_data  = data_q[PIPE_STAGES-1];
    assign blk_cnt   = cnt_q;

    // Whole pipe freezes when the head is blocked; bubbles are never squeezed out.
    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q[0]  <= 1'b0;
            mode_q[0] <= 1'b0;
            data_q[0] <= '0;
        end else if (!stall) begin
            vld_q[0] <= in_valid;
            if (in_valid) begin
                mode_q[0] <= in_mode;
                data_q[0] <= permute(in_data, in_mode);
            end
        end
    end

    for (genvar s = 1; s < PIPE_STAGES; s++) begin : g_delay
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_q[s]  <= 1'b0;
                mode_q[s] <= 1'b0;
                data_q[s] <= '0;
            end else if (!stall) begin
                vld_q[s]  <= vld_q[s-1];
                mode_q[s] <= mode_q[s-1];
                data_q[s] <= data_q[s-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (out_valid && out_ready) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

`ifdef DES_PERM_SELFCHECK_EN
    logic [PIPE_STAGES-1:0][63:0] orig_q;
    logic                         chk_err_q;
    logic                         mismatch;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            orig_q[0] <= '0;
        end else if (!stall && in_valid) begin
            orig_q[0] <= in_data;
        end
    end

    for (genvar s = 1; s < PIPE_STAGES; s++) begin : g_orig
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                orig_q[s] <= '0;
            end else if (!stall) begin
                orig_q[s] <= orig_q[s-1];
            end
        end
    end

    // Inverting with the opposite table must recover the carried original block.
    assign mismatch = out_valid && (permute(out_data, ~out_mode) != orig_q[PIPE_STAGES-1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chk_err_q <= 1'b0;
        end else if (mismatch) begin
            chk_err_q <= 1'b1;
        end
    end

    assign chk_err = chk_err_q;
`else
    assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_des_perm_pipe.sv
// Directed bench for des_perm_pipe: known-answer table, streaming, stall, counter wrap, reset.
module tb_des_perm_pipe;

    localparam int unsigned PS = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_mode, out_ready;
    logic [63:0] in_data;
    logic        in_ready, out_valid, out_mode, chk_err;
    logic [63:0] out_data;
    logic [15:0] blk_cnt;
    logic        s_in_ready, s_out_valid, s_out_mode, s_chk_err;
    logic [63:0] s_out_data;
    logic [3:0]  s_blk_cnt;

    always #5 clk = ~clk;

    des_perm_pipe #(.PIPE_STAGES(PS), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_mode(out_mode),
        .out_data(out_data), .blk_cnt(blk_cnt), .chk_err(chk_err)
    );

    des_perm_pipe #(.PIPE_STAGES(PS), .CNT_W(4)) dut_w4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .in_mode(in_mode),
        .in_data(in_data), .out_valid(s_out_valid), .out_ready(out_ready),
        .out_mode(s_out_mode), .out_data(s_out_data), .blk_cnt(s_blk_cnt),
        .chk_err(s_chk_err)
    );

    typedef struct { logic mode; logic [63:0] din; logic [63:0] dout; } vec_t;
    typedef struct { logic mode; logic [63:0] data; } exp_t;

    vec_t tbl [8];
    exp_t sb [$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   exp_cnt = 0;
    int   cur = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
        end
    endtask

    task automatic drive(input int idx);
        cur      = idx;
        in_valid = 1'b1;
        in_mode  = tbl[idx].mode;
        in_data  = tbl[idx].din;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_mode  = 1'($urandom);
        in_data  = {$urandom, $urandom};
    endtask

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic cycle();
        exp_t e;
        #1;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_out: got %h want no block", out_data);
            end else begin
                e = sb.pop_front();
                chk("out_data", out_data, e.data);
                chk("out_mode", 64'(out_mode), 64'(e.mode));
                chk("w4_out_data", s_out_data, e.data);
                exp_cnt++;
            end
        end
        if (in_valid && in_ready) begin
            e.mode = tbl[cur].mode;
            e.data = tbl[cur].dout;
            sb.push_back(e);
        end
        @(negedge clk);
        chk("blk_cnt", 64'(blk_cnt), 64'(exp_cnt % 65536));
        chk("blk_cnt_w4", 64'(s_blk_cnt), 64'(exp_cnt % 16));
    endtask

    task automatic drain();
        idle();
        for (int i = 0; i < 40 && sb.size() > 0; i++) cycle();
        chk("drain_empty", 64'(sb.size()), 64'd0);
        chk("drain_valid", 64'(out_valid), 64'd0);
    endtask

    task automatic kat(input int idx);
        int lat;
        drive(idx);
        cycle();
        idle();
        lat = 0;
        while (!out_valid && lat < 20) begin
            cycle();
            lat++;
        end
        chk("latency", 64'(lat), 64'(PS - 1));
        chk("kat_data", out_data, tbl[idx].dout);
        chk("kat_mode", 64'(out_mode), 64'(tbl[idx].mode));
        cycle();
    endtask

    initial begin
        logic [63:0] hold;
        tbl[0] = '{1'b0, 64'h0123456789ABCDEF, 64'hCC00CCFFF0AAF0AA};
        tbl[1] = '{1'b1, 64'hCC00CCFFF0AAF0AA, 64'h0123456789ABCDEF};
        tbl[2] = '{1'b0, 64'h8000000000000000, 64'h0000000001000000};
        tbl[3] = '{1'b1, 64'h8000000000000000, 64'h0000000000000040};
        tbl[4] = '{1'b0, 64'h0000000000000001, 64'h0000008000000000};
        tbl[5] = '{1'b1, 64'h0000000000000001, 64'h0200000000000000};
        tbl[6] = '{1'b0, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF};
        tbl[7] = '{1'b1, 64'h0000000001000000, 64'h8000000000000000};

        rst       = 1'b1;
        out_ready = 1'b1;
        idle();
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_mode", 64'(out_mode), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_blk_cnt", 64'(blk_cnt), 64'd0);
        chk("rst_chk_err", 64'(chk_err), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        rst = 1'b0;
        @(negedge clk);

        // Single-block known answers with latency, one per table entry.
        for (int i = 0; i < 8; i++) kat(i);

        // 16 back-to-back alternating-mode blocks; outputs must be contiguous.
        for (int j = 0; j < int'(PS) + 17; j++) begin
            if (j < 16) drive(j % 8);
            else idle();
            #1;
            chk("stream_valid", 64'(out_valid), 64'(j >= int'(PS) && j < int'(PS) + 16));
            #1;
            cycle();
        end
        drain();
        chk("stream_cnt", 64'(blk_cnt), 64'd24);
        chk("stream_chk_err", 64'(chk_err), 64'd0);

        // Fill the pipe against a blocked sink, hold for 5 cycles, then release.
        out_ready = 1'b0;
        for (int k = 0; k < int'(PS); k++) begin
            drive(k);
            cycle();
        end
        drive(PS % 8);
        hold = out_data;
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            chk("stall_w4_in_ready", 64'(s_in_ready), 64'd0);
            chk("stall_out_valid", 64'(out_valid), 64'd1);
            chk("stall_hold", out_data, hold);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive((k + 4) % 8);
            cycle();
        end
        drain();
        chk("bp_cnt", 64'(blk_cnt), 64'd24 + 64'(PS) + 64'd4);

        // Asynchronous reset with blocks in flight and one at the head.
        for (int k = 0; k < int'(PS); k++) begin
            drive(k + 1);
            cycle();
        end
        idle();
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_valid", 64'(out_valid), 64'd0);
        chk("rst_mid_cnt", 64'(blk_cnt), 64'd0);
        chk("rst_mid_cnt_w4", 64'(s_blk_cnt), 64'd0);
        chk("rst_mid_in_ready", 64'(in_ready), 64'd1);
        sb.delete();
        exp_cnt = 0;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < int'(PS) + 1; k++) begin
            cycle();
            chk("post_rst_no_ghost", 64'(out_valid), 64'd0);
        end
        kat(3);
        kat(0);
        drain();
        chk("final_chk_err", 64'(chk_err), 64'd0);
        chk("final_cnt", 64'(blk_cnt), 64'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/des_perm_pipe.md
# des_perm_pipe

Parametrised, pipelined DES bit-permutation engine. It applies either the Initial Permutation (IP) or the Final Permutation (FP = IP⁻¹) to 64-bit blocks, selected per block. It uses a valid/ready handshake with full-pipeline backpressure. It sits between the key-schedule/round datapath and the block I/O, and serves both the entry (IP) and exit (FP) of the cipher core.

## Interface
Parameters:
- PIPE_STAGES, 2, register stages from input to output; legal 1..4; the permutation is applied in stage 1.
- CNT_W, 16, width of the delivered-block counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input block valid.
- in_ready  out  1  engine can accept this cycle.
- in_mode  in  1  0 = IP, 1 = FP; sampled with the block.
- in_data  in  64  block; DES bit n (1-indexed) = in_data[64-n].
- out_valid  out  1  output block valid.
- out_ready  in  1  downstream accepts.
- out_mode  out  1  mode carried with the block.
- out_data  out  64  permuted block, same bit convention.
- blk_cnt  out  CNT_W  count of delivered blocks.
- chk_err  out  1  sticky self-check failure (see Configuration).

## Operation
- Output DES bit i = input DES bit P[i]. P = IP or FP per standard FIPS 46-3 tables.
  - IP row 1 = 58 50 42 34 26 18 10 2.
  - FP row 1 = 40 8 48 16 56 24 64 32.
- Pipeline of PIPE_STAGES registers. Each stage holds {valid, mode, data}. Stage 1 holds permuted data; later stages are pure delay.
- Global stall: stall = out_valid & ~out_ready. in_ready = ~stall. On a non-stall cycle every stage shifts one place, and stage 1 loads the input if in_valid, else a bubble.
- Bubbles are not compressed. A non-full pipe still stalls when the head is blocked.
- Transfer in = in_valid & in_ready. Transfer out = out_valid & out_ready.
- blk_cnt increments by 1 per out transfer and wraps from 2^CNT_W−1 to 0.
- Mode is per block. Mixed IP/FP streams are legal back-to-back, with no flush.

## Timing
- Reset values:
  - out_valid = 0, out_mode = 0, out_data = 0, blk_cnt = 0, chk_err = 0.
  - All stage valids = 0.
  - in_ready = 1, because it is derived.
- Latency: a block accepted at edge k appears on out_valid/out_data after edge k+PIPE_STAGES−1. That is, PIPE_STAGES cycles from in transfer to first out_valid cycle, absent stalls.
- Throughput: one block per cycle while out_ready = 1.
- Backpressure:
  - While stalled, out_data and out_mode hold stable and all stages freeze.
  - in_ready = 0 in the same cycle (combinational from out_ready).
- Simultaneous in and out transfer in one cycle is legal and loses no data.
- An in_valid drop mid-stream inserts a bubble that propagates with the pipe.
- rst mid-operation: every in-flight block is discarded, all valids clear immediately (asynchronous), and blk_cnt returns to 0. The first accept after rst deasserts behaves as from power-up.
- in_data and in_mode are don't-care when in_valid = 0.

## Configuration
- DES_PERM_SELFCHECK_EN defined:
  - Each stage also carries the original input block.
  - At the output, the inverse permutation is applied to out_data (FP⁻¹ = IP for mode 1, IP⁻¹ = FP for mode 0) and compared with the carried original.
  - On mismatch while out_valid = 1, chk_err is set. It stays set until rst.
- Not defined: no input copy is stored, no comparator is built, and chk_err is tied to 0.

## Test plan
- IP known answer: mode 0, data 0x0123456789ABCDEF -> out_data 0xCC00CCFFF0AAF0AA, out_mode 0, exactly PIPE_STAGES cycles after accept; blk_cnt = 1.
- FP known answer and inverse: mode 1, 0xCC00CCFFF0AAF0AA -> 0x0123456789ABCDEF. Single-bit input 0x8000000000000000 gives 0x0000000001000000 in mode 0 and 0x0000000000000040 in mode 1.
- Streaming mixed modes: 16 back-to-back blocks alternating mode with out_ready = 1 -> 16 outputs on consecutive cycles, in order, each mode correct; blk_cnt = 16; chk_err = 0.
- Backpressure: hold out_ready = 0 for 5 cycles with a full pipe -> in_ready = 0, out_data stable, no loss or duplication after release.
- Counter wrap (CNT_W = 4): 17 blocks -> blk_cnt sequence reaches 15, then 0, then 1.
- Reset mid-stream: assert rst with 2 blocks in flight -> out_valid = 0 and blk_cnt = 0 immediately; the next block after release emerges after PIPE_STAGES cycles with correct data.
